// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the PCPU hazard scoreboard.
// Holds the default geometry of the scoreboard, the forward-select encoding
// driven onto the EX operand muxes, and the producer latency encoding
// presented at ID.
package hazard_scoreboard_pkg;

  localparam int unsigned HSB_NSRC   = 3;
  localparam int unsigned HSB_NREG   = 32;
  localparam int unsigned HSB_AW     = 5;
  localparam int unsigned HSB_WB_AGE = 3;
  localparam int unsigned HSB_FW     = 2;
  localparam int unsigned HSB_MD_W   = 6;
  localparam int unsigned HSB_CNT_W  = 32;

  // EX operand source: 0 = register file, k = pipeline register at producer age k.
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  // Number of ages a producer needs before its result can be forwarded.
  typedef enum logic [1:0] {
    LAT_ALU  = 2'd1,
    LAT_LOAD = 2'd2
  } lat_e;

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: tracks the youngest in-flight write to a single
// architectural register.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   adv_i          pipeline advances; entry is frozen when low
//   set_i          a new producer of this register issues this cycle
//   flush_i        the producer currently in EX is killed
//   lat_i          latency of the issuing producer (0 is treated as 1)
//   valid_o        entry holds an in-flight producer
//   age_o          producer age (0 = EX)
//   lat_o          producer latency in ages
module hazard_scoreboard_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned FW     = HSB_FW,
  parameter int unsigned WB_AGE = HSB_WB_AGE
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          adv_i,
  input  logic          set_i,
  input  logic          flush_i,
  input  logic [FW-1:0] lat_i,
  output logic          valid_o,
  output logic [FW-1:0] age_o,
  output logic [FW-1:0] lat_o
);

  logic          valid_q, valid_d;
  logic [FW-1:0] age_q, age_d;
  logic [FW-1:0] lat_q, lat_d;

  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    lat_d   = lat_q;
    if (adv_i) begin
      if (set_i) begin
        // A new producer always replaces the older one, even one retiring now.
        valid_d = 1'b1;
        age_d   = '0;
        lat_d   = (lat_i == '0) ? FW'(LAT_ALU) : lat_i;
      end else if (valid_q) begin
        // The RF is write-first, so the producer leaves as it passes WB.
        if ((flush_i && age_q == '0) || age_q == FW'(WB_AGE - 1)) begin
          valid_d = 1'b0;
        end else begin
          age_d = age_q + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      age_q   <= '0;
      lat_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
      lat_q   <= lat_d;
    end
  end

  assign valid_o = valid_q;
  assign age_o   = age_q;
  assign lat_o   = lat_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard detection and forwarding control for the PCPU.
// Tracks every in-flight register write and the MULT/DIV unit, decides the
// ID stall, and produces registered forward selects for the EX operand muxes.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   adv_i               pipeline advances this cycle
//   id_valid_i          IF/ID holds a real instruction
//   id_src_i            source register indices, port s at [s*AW +: AW]
//   id_src_en_i         port s is actually read
//   id_rf_wr_i, id_rd_i instruction writes register id_rd_i
//   id_lat_i            ages until result is forwardable
//   id_md_start_i       instruction starts MULT/DIV for id_md_cycles_i cycles
//   id_md_use_i         instruction needs HI/LO or the MD unit
//   ex_flush_i          kill the producer currently in EX
//   stall_o             ID hazard this cycle
//   pc_wr_o, ifid_wr_o  front-end write enables
//   idex_bubble_o       insert a bubble into ID/EX
//   ex_fwd_sel_o        registered per-port EX forward select
//   md_busy_o           MULT/DIV unit busy
//   stall_cnt_o         saturating count of stall cycles that cost an advance
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSRC   = HSB_NSRC,
  parameter int unsigned NREG   = HSB_NREG,
  parameter int unsigned AW     = HSB_AW,
  parameter int unsigned WB_AGE = HSB_WB_AGE,
  parameter int unsigned FW     = HSB_FW,
  parameter int unsigned MD_W   = HSB_MD_W,
  parameter int unsigned CNT_W  = HSB_CNT_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 adv_i,
  input  logic                 id_valid_i,
  input  logic [NSRC*AW-1:0]   id_src_i,
  input  logic [NSRC-1:0]      id_src_en_i,
  input  logic                 id_rf_wr_i,
  input  logic [AW-1:0]        id_rd_i,
  input  logic [FW-1:0]        id_lat_i,
  input  logic                 id_md_start_i,
  input  logic [MD_W-1:0]      id_md_cycles_i,
  input  logic                 id_md_use_i,
  input  logic                 ex_flush_i,
  output logic                 stall_o,
  output logic                 pc_wr_o,
  output logic                 ifid_wr_o,
  output logic                 idex_bubble_o,
  output logic [NSRC*FW-1:0]   ex_fwd_sel_o,
  output logic                 md_busy_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  logic [NREG-1:0] ent_valid;
  logic [FW-1:0]   ent_age [NREG];
  logic [FW-1:0]   ent_lat [NREG];

  logic                stall, issue, md_haz;
  logic [NSRC-1:0]     port_haz;
  logic [NSRC*FW-1:0]  fwd_next;
  logic [NSRC*FW-1:0]  fwd_q, fwd_d;
  logic [MD_W-1:0]     md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  // Register 0 is hard-wired and never has a producer.
  assign ent_valid[0] = 1'b0;
  assign ent_age[0]   = '0;
  assign ent_lat[0]   = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    hazard_scoreboard_entry #(
      .FW     (FW),
      .WB_AGE (WB_AGE)
    ) u_ent (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .adv_i   (adv_i),
      .set_i   (issue && id_rf_wr_i && (id_rd_i == AW'(r))),
      .flush_i (ex_flush_i),
      .lat_i   (id_lat_i),
      .valid_o (ent_valid[r]),
      .age_o   (ent_age[r]),
      .lat_o   (ent_lat[r])
    );
  end

  always_comb begin
    logic [AW-1:0] src;
    logic [FW:0]   age_p1;
    logic          live;
    port_haz = '0;
    fwd_next = '0;
    src      = '0;
    age_p1   = '0;
    live     = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      src    = id_src_i[s*AW +: AW];
      age_p1 = {1'b0, ent_age[src]} + (FW+1)'(1);
      // A producer being flushed out of EX this cycle no longer blocks ID.
      live   = ent_valid[src] && !(ex_flush_i && adv_i && ent_age[src] == '0);
      if (id_src_en_i[s] && src != '0 && live && age_p1 < {1'b0, ent_lat[src]}) begin
        port_haz[s] = 1'b1;
      end
      if (ent_valid[src] && age_p1 < (FW+1)'(WB_AGE)) begin
        fwd_next[s*FW +: FW] = age_p1[FW-1:0];
      end
    end
  end

  assign md_haz = id_md_use_i && (md_cnt_q != '0);
  assign stall  = id_valid_i && ((|port_haz) || md_haz);
  assign issue  = id_valid_i && !stall && adv_i;

  always_comb begin
    md_cnt_d    = md_cnt_q;
    fwd_d       = fwd_q;
    stall_cnt_d = stall_cnt_q;

    // The MD unit runs on its own and keeps counting through memory stalls.
    if (issue && id_md_start_i) begin
      md_cnt_d = id_md_cycles_i;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end

    if (adv_i) begin
      if (!issue || ex_flush_i) begin
        fwd_d = {NSRC{FW'(FWD_RF)}};
      end else begin
        fwd_d = fwd_next;
      end
    end

    if (stall && adv_i && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      md_cnt_q    <= '0;
      fwd_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      fwd_q       <= fwd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_o       = stall;
  assign pc_wr_o       = !stall && adv_i;
  assign ifid_wr_o     = !stall && adv_i;
  assign idex_bubble_o = stall && adv_i;
  assign ex_fwd_sel_o  = fwd_q;
  assign md_busy_o     = (md_cnt_q != '0);
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int unsigned NSRC  = 3;
  localparam int unsigned AW    = 5;
  localparam int unsigned FW    = 2;
  localparam int unsigned MD_W  = 6;
  localparam int unsigned CNT_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               adv;
  logic               id_valid;
  logic [NSRC*AW-1:0] id_src;
  logic [NSRC-1:0]    id_src_en;
  logic               id_rf_wr;
  logic [AW-1:0]      id_rd;
  logic [FW-1:0]      id_lat;
  logic               id_md_start;
  logic [MD_W-1:0]    id_md_cycles;
  logic               id_md_use;
  logic               ex_flush;
  logic               stall, pc_wr, ifid_wr, idex_bubble, md_busy;
  logic [NSRC*FW-1:0] ex_fwd_sel;
  logic [CNT_W-1:0]   stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_scoreboard dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .adv_i          (adv),
    .id_valid_i     (id_valid),
    .id_src_i       (id_src),
    .id_src_en_i    (id_src_en),
    .id_rf_wr_i     (id_rf_wr),
    .id_rd_i        (id_rd),
    .id_lat_i       (id_lat),
    .id_md_start_i  (id_md_start),
    .id_md_cycles_i (id_md_cycles),
    .id_md_use_i    (id_md_use),
    .ex_flush_i     (ex_flush),
    .stall_o        (stall),
    .pc_wr_o        (pc_wr),
    .ifid_wr_o      (ifid_wr),
    .idex_bubble_o  (idex_bubble),
    .ex_fwd_sel_o   (ex_fwd_sel),
    .md_busy_o      (md_busy),
    .stall_cnt_o    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] sel(input int s);
    return ex_fwd_sel[s*FW +: FW];
  endfunction

  task automatic drv(input logic v, input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                     input logic [NSRC-1:0] en, input logic wr, input logic [AW-1:0] rd,
                     input logic [FW-1:0] lat, input logic mds, input logic [MD_W-1:0] mdc,
                     input logic mdu);
    id_valid     = v;
    id_src       = {5'd0, s1, s0};
    id_src_en    = en;
    id_rf_wr     = wr;
    id_rd        = rd;
    id_lat       = lat;
    id_md_start  = mds;
    id_md_cycles = mdc;
    id_md_use    = mdu;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 2'd0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; adv = 1'b1; ex_flush = 1'b0;
    idle();
    tick(); tick();
    rst = 1'b0;
    chk("init_sel0", 32'(sel(0)), 32'd0);
    chk("init_stall_cnt", stall_cnt, 32'd0);

    // 1: reset in the middle of a lw and a running mult
    drv(1'b1, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 2'd0, 1'b1, 6'd7, 1'b1);
    chk("t1_mult_stall", 32'(stall), 32'd0);
    tick();
    drv(1'b1, 5'd29, 5'd0, 3'b001, 1'b1, 5'd4, LAT_LOAD, 1'b0, 6'd0, 1'b0);
    tick();
    chk("t1_md_busy_pre", 32'(md_busy), 32'd1);
    drv(1'b0, 5'd4, 5'd4, 3'b011, 1'b0, 5'd0, 2'd0, 1'b0, 6'd0, 1'b0);
    chk("t1_invalid_nostall", 32'(stall), 32'd0);
    chk("t1_invalid_pcwr", 32'(pc_wr), 32'd1);
    rst = 1'b1;
    idle();
    tick(); tick();
    rst = 1'b0;
    chk("t1_md_busy", 32'(md_busy), 32'd0);
    chk("t1_stall_cnt", stall_cnt, 32'd0);
    chk("t1_sel0", 32'(sel(0)), 32'd0);
    drv(1'b1, 5'd4, 5'd4, 3'b011, 1'b1, 5'd5, LAT_ALU, 1'b0, 6'd0, 1'b1);
    chk("t1_after_rst_stall", 32'(stall), 32'd0);
    tick();
    idle(); tick(); tick(); tick();

    // 2: ALU result forwarded from EX/MEM
    drv(1'b1, 5'd1, 5'd2, 3'b011, 1'b1, 5'd3, LAT_ALU, 1'b0, 6'd0, 1'b0);
    chk("t2_add_stall", 32'(stall), 32'd0);
    tick();
    drv(1'b1, 5'd3, 5'd2, 3'b011, 1'b1, 5'd1, LAT_ALU, 1'b0, 6'd0, 1'b0);
    chk("t2_sub_stall", 32'(stall), 32'd0);
    tick();
    chk("t2_sel0", 32'(sel(0)), 32'(FWD_EXMEM));
    chk("t2_sel1", 32'(sel(1)), 32'(FWD_RF));
    idle(); tick();
    chk("t2_idle_sel0", 32'(sel(0)), 32'd0);
    tick(); tick();

    // 3: load-use costs one bubble, then forwards from MEM/WB
    drv(1'b1, 5'd29, 5'd0, 3'b001, 1'b1, 5'd4, LAT_LOAD, 1'b0, 6'd0, 1'b0);
    tick();
    drv(1'b1, 5'd4, 5'd4, 3'b011, 1'b1, 5'd5, LAT_ALU, 1'b0, 6'd0, 1'b0);
    chk("t3_stall", 32'(stall), 32'd1);
    chk("t3_bubble", 32'(idex_bubble), 32'd1);
    chk("t3_pc_wr", 32'(pc_wr), 32'd0);
    chk("t3_ifid_wr", 32'(ifid_wr), 32'd0);
    tick();
    chk("t3_bubble_sel", 32'(sel(0)), 32'd0);
    chk("t3_stall_again", 32'(stall), 32'd0);
    chk("t3_pc_wr_issue", 32'(pc_wr), 32'd1);
    tick();
    chk("t3_sel0", 32'(sel(0)), 32'(FWD_MEMWB));
    chk("t3_sel1", 32'(sel(1)), 32'(FWD_MEMWB));
    chk("t3_stall_cnt", stall_cnt, 32'd1);
    adv = 1'b0;
    idle(); tick();
    chk("t3_sel_held", 32'(sel(0)), 32'(FWD_MEMWB));
    adv = 1'b1;
    tick(); tick(); tick();

    // 4: WAW, youngest producer (lw) decides the hazard
    drv(1'b1, 5'd1, 5'd2, 3'b011, 1'b1, 5'd5, LAT_ALU, 1'b0, 6'd0, 1'b0);
    tick();
    drv(1'b1, 5'd29, 5'd0, 3'b001, 1'b1, 5'd5, LAT_LOAD, 1'b0, 6'd0, 1'b0);
    tick();
    drv(1'b1, 5'd5, 5'd0, 3'b011, 1'b1, 5'd6, LAT_ALU, 1'b0, 6'd0, 1'b0);
    chk("t4_stall", 32'(stall), 32'd1);
    tick();
    chk("t4_stall_2nd", 32'(stall), 32'd0);
    tick();
    chk("t4_sel0", 32'(sel(0)), 32'(FWD_MEMWB));
    chk("t4_sel1", 32'(sel(1)), 32'd0);
    chk("t4_stall_cnt", stall_cnt, 32'd2);
    idle(); tick(); tick(); tick();

    // 5: mflo behind a 5-cycle mult
    drv(1'b1, 5'd8, 5'd9, 3'b011, 1'b0, 5'd0, 2'd0, 1'b1, 6'd5, 1'b1);
    chk("t5_mult_stall", 32'(stall), 32'd0);
    tick();
    chk("t5_md_busy", 32'(md_busy), 32'd1);
    drv(1'b1, 5'd0, 5'd0, 3'b000, 1'b1, 5'd10, LAT_ALU, 1'b0, 6'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_stall_c%0d", i + 1), 32'(stall), 32'd1);
      tick();
    end
    chk("t5_issue_c6", 32'(stall), 32'd0);
    chk("t5_md_idle", 32'(md_busy), 32'd0);
    tick();
    chk("t5_stall_cnt", stall_cnt, 32'd7);
    idle(); tick(); tick(); tick();

    // 6: memory stall freezes the scoreboard
    drv(1'b1, 5'd29, 5'd0, 3'b001, 1'b1, 5'd7, LAT_LOAD, 1'b0, 6'd0, 1'b0);
    tick();
    adv = 1'b0;
    drv(1'b1, 5'd7, 5'd0, 3'b001, 1'b1, 5'd9, LAT_ALU, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6_frz_stall%0d", i), 32'(stall), 32'd1);
      chk($sformatf("t6_frz_pcwr%0d", i), 32'(pc_wr), 32'd0);
      chk($sformatf("t6_frz_bubble%0d", i), 32'(idex_bubble), 32'd0);
      tick();
    end
    chk("t6_frz_cnt", stall_cnt, 32'd7);
    adv = 1'b1;
    #1;
    chk("t6_resume_stall", 32'(stall), 32'd1);
    tick();
    chk("t6_resume_cnt", stall_cnt, 32'd8);
    chk("t6_issue_stall", 32'(stall), 32'd0);
    tick();
    chk("t6_sel0", 32'(sel(0)), 32'(FWD_MEMWB));
    idle(); tick(); tick(); tick();

    // 6b: flush of the lw in EX lets the dependent add go
    drv(1'b1, 5'd29, 5'd0, 3'b001, 1'b1, 5'd7, LAT_LOAD, 1'b0, 6'd0, 1'b0);
    tick();
    ex_flush = 1'b1;
    drv(1'b1, 5'd7, 5'd0, 3'b001, 1'b1, 5'd9, LAT_ALU, 1'b0, 6'd0, 1'b0);
    chk("t6_flush_stall", 32'(stall), 32'd0);
    tick();
    ex_flush = 1'b0;
    chk("t6_flush_sel0", 32'(sel(0)), 32'd0);
    drv(1'b1, 5'd7, 5'd0, 3'b001, 1'b1, 5'd10, LAT_ALU, 1'b0, 6'd0, 1'b0);
    chk("t6_postflush_stall", 32'(stall), 32'd0);
    tick();
    chk("t6_postflush_sel0", 32'(sel(0)), 32'd0);
    chk("t6_final_cnt", stall_cnt, 32'd8);
    idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
